// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) feeding the
// seven-segment scanner; bcd_out/ovf are a holding register updated only on done.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [4*DIGITS-1:0] bcd_out
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    function automatic logic [63:0] max_val(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_val(DIGITS);

    // Digits are <= 9 before every shift, so a 4-bit +3 never carries out.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;

    logic [ACC_W-1:0]       adj_s;
    logic [ACC_W+BIN_W-1:0] shift_s;

    assign adj_s   = add3_digits(acc_q);
    assign shift_s = {adj_s, sh_q} << 1;

    // Next-state and datapath control for the IDLE/SHIFT converter.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (64'(bin_in) > MAXV) begin
                        bcd_d  = {DIGITS{4'h9}};
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        sh_d    = bin_in;
                        acc_d   = {ACC_W{1'b0}};
                        cnt_d   = CNT_W'(BIN_W - 1);
                        busy_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            SHIFT: begin
                acc_d = shift_s[ACC_W+BIN_W-1 -: ACC_W];
                sh_d  = shift_s[BIN_W-1:0];
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    bcd_d   = shift_s[ACC_W+BIN_W-1 -: ACC_W];
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and working/holding registers; reset aborts any conversion.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            sh_q    <= {BIN_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= {ACC_W{1'b0}};
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign bcd_out = bcd_q;

endmodule
